// File: rtl/data_memory.sv
// Byte-addressed big-endian data memory for the MEM stage: combinational word reads
// on a tri-state port, word writes committed on the falling clock edge.
module data_memory #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AW    = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [AW-1:0] Address,
  input  logic [31:0]   WriteData,
  input  logic          MemRead,
  input  logic          MemWrite,
  output tri   [31:0]   DataOut
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned EW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [EW-1:0] last_byte;
  logic          in_range;
  logic [IW-1:0] idx0;
  logic [IW-1:0] idx1;
  logic [IW-1:0] idx2;
  logic [IW-1:0] idx3;
  logic [31:0]   read_word_c;

  // One extra bit keeps Address near the top of the space from wrapping into range.
  assign last_byte = {1'b0, Address} + EW'(3);
  assign in_range  = (last_byte < EW'(DEPTH));

  // Only meaningful when in_range; the whole word then lies inside the array.
  assign idx0 = Address[IW-1:0];
  assign idx1 = idx0 + IW'(1);
  assign idx2 = idx0 + IW'(2);
  assign idx3 = idx0 + IW'(3);

  always_comb begin
    read_word_c = 32'h0000_0000;
    if (in_range) begin
      read_word_c = {mem[idx0], mem[idx1], mem[idx2], mem[idx3]};
    end
  end

  assign DataOut = MemRead ? {32{1'bz}} : read_word_c;

  // Falling-edge commit leaves the rising edge free for the PC and register file.
  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[IW'(i)] <= 8'h00;
      end
    end else if (!MemWrite && in_range) begin
      mem[idx0] <= WriteData[31:24];
      mem[idx1] <= WriteData[23:16];
      mem[idx2] <= WriteData[15:8];
      mem[idx3] <= WriteData[7:0];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory; the read bus has a pull-up so an
// undriven (high-Z) port reads back as all ones.
module tb_data_memory;

  localparam int unsigned DEPTH = 128;
  localparam int unsigned AW    = 32;
  localparam logic [31:0] ZVAL  = 32'hFFFF_FFFF;

  logic          CLK;
  logic          RST;
  logic [AW-1:0] Address;
  logic [31:0]   WriteData;
  logic          MemRead;
  logic          MemWrite;
  tri1  [31:0]   DataOut;

  int vectors;
  int miscompares;

  data_memory #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Address   (Address),
    .WriteData (WriteData),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .DataOut   (DataOut)
  );

  initial CLK = 1'b0;
  always #15 CLK = ~CLK;

  // Drive one word write across the next falling edge, then disable writing.
  task automatic write_word(input logic [AW-1:0] a, input logic [31:0] d);
    @(posedge CLK);
    #1;
    Address   = a;
    WriteData = d;
    MemWrite  = 1'b0;
    MemRead   = 1'b1;
    @(negedge CLK);
    #1;
    MemWrite  = 1'b1;
  endtask

  task automatic test_reset;
    RST = 1'b0; MemRead = 1'b0; MemWrite = 1'b1; Address = 32'd8; WriteData = 32'h0;
    #7;
    vectors++;
    if (DataOut !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL reset_read_en: got %h want %h", DataOut, 32'h0000_0000);
    end
    MemRead = 1'b1;
    #1;
    vectors++;
    if (DataOut !== ZVAL) begin
      miscompares++;
      $display("FAIL reset_read_dis: got %h want high-Z", DataOut);
    end
    @(posedge CLK);
    #1;
    RST = 1'b1;
    MemRead = 1'b0;
    #1;
    vectors++;
    if (DataOut !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL post_reset_read: got %h want %h", DataOut, 32'h0000_0000);
    end
    MemRead = 1'b1;
    #1;
    vectors++;
    if (DataOut !== ZVAL) begin
      miscompares++;
      $display("FAIL post_reset_z: got %h want high-Z", DataOut);
    end
  endtask

  task automatic test_basic;
    logic [AW-1:0] addrs [2];
    logic [31:0]   exps  [2];
    addrs[0] = 32'd8;  exps[0] = 32'h0000_0008;
    addrs[1] = 32'd12; exps[1] = 32'h0000_000C;
    write_word(32'd8, 32'd8);
    write_word(32'd12, 32'd12);
    MemRead = 1'b0;
    for (int i = 0; i < 2; i++) begin
      Address = addrs[i];
      #1;
      vectors++;
      if (DataOut !== exps[i]) begin
        miscompares++;
        $display("FAIL basic_read @%0d: got %h want %h", addrs[i], DataOut, exps[i]);
      end
    end
  endtask

  task automatic test_endian;
    logic [AW-1:0] addrs [3];
    logic [31:0]   exps  [3];
    addrs[0] = 32'd0; exps[0] = 32'h1122_3344;
    addrs[1] = 32'd1; exps[1] = 32'h2233_4400;
    addrs[2] = 32'd3; exps[2] = 32'h4400_0000;
    write_word(32'd0, 32'h1122_3344);
    MemRead = 1'b0;
    for (int i = 0; i < 3; i++) begin
      Address = addrs[i];
      #1;
      vectors++;
      if (DataOut !== exps[i]) begin
        miscompares++;
        $display("FAIL endian_read @%0d: got %h want %h", addrs[i], DataOut, exps[i]);
      end
    end
  endtask

  task automatic test_write_timing;
    @(negedge CLK);
    #1;
    Address = 32'd16; WriteData = 32'hDEAD_BEEF; MemWrite = 1'b0; MemRead = 1'b0;
    #1;
    vectors++;
    if (DataOut !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL wt_before_edge: got %h want %h", DataOut, 32'h0000_0000);
    end
    @(posedge CLK);
    #1;
    vectors++;
    if (DataOut !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL wt_after_rise: got %h want %h", DataOut, 32'h0000_0000);
    end
    @(negedge CLK);
    #1;
    vectors++;
    if (DataOut !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL wt_after_fall: got %h want %h", DataOut, 32'hDEAD_BEEF);
    end
    MemWrite = 1'b1; WriteData = 32'h1234_5678;
    @(negedge CLK);
    #1;
    vectors++;
    if (DataOut !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL wt_no_write: got %h want %h", DataOut, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_overlap;
    logic [AW-1:0] addrs [3];
    logic [31:0]   exps  [3];
    addrs[0] = 32'd8; exps[0] = 32'hC3D4_0008;
    addrs[1] = 32'd4; exps[1] = 32'h0000_A1B2;
    addrs[2] = 32'd3; exps[2] = 32'h4400_00A1;
    write_word(32'd6, 32'hA1B2_C3D4);
    MemRead = 1'b0;
    for (int i = 0; i < 3; i++) begin
      Address = addrs[i];
      #1;
      vectors++;
      if (DataOut !== exps[i]) begin
        miscompares++;
        $display("FAIL overlap_read @%0d: got %h want %h", addrs[i], DataOut, exps[i]);
      end
    end
  endtask

  task automatic test_out_of_range;
    logic [AW-1:0] addrs [6];
    logic [31:0]   exps  [6];
    addrs[0] = 32'(DEPTH - 2); exps[0] = 32'h0000_0000;
    addrs[1] = 32'(DEPTH - 4); exps[1] = 32'h0000_0000;
    addrs[2] = 32'(DEPTH - 1); exps[2] = 32'h0000_0000;
    addrs[3] = 32'hFFFF_FFFD;  exps[3] = 32'h0000_0000;
    addrs[4] = 32'd0;          exps[4] = 32'h1122_3344;
    addrs[5] = 32'd1000;       exps[5] = 32'h0000_0000;
    write_word(32'(DEPTH - 2), 32'hFFFF_FFFF);
    write_word(32'hFFFF_FFFD, 32'h5555_5555);
    MemRead = 1'b0;
    for (int i = 0; i < 6; i++) begin
      Address = addrs[i];
      #1;
      vectors++;
      if (DataOut !== exps[i]) begin
        miscompares++;
        $display("FAIL oor_read @%h: got %h want %h", addrs[i], DataOut, exps[i]);
      end
    end
    write_word(32'(DEPTH - 4), 32'h0102_0304);
    MemRead = 1'b0;
    Address = 32'(DEPTH - 4);
    #1;
    vectors++;
    if (DataOut !== 32'h0102_0304) begin
      miscompares++;
      $display("FAIL last_word_read: got %h want %h", DataOut, 32'h0102_0304);
    end
    Address = 32'(DEPTH - 3);
    #1;
    vectors++;
    if (DataOut !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL straddle_read: got %h want %h", DataOut, 32'h0000_0000);
    end
  endtask

  task automatic test_back_to_back;
    @(posedge CLK);
    #1;
    MemRead = 1'b1; MemWrite = 1'b0;
    Address = 32'd20; WriteData = 32'hCAFE_F00D;
    @(negedge CLK);
    #1;
    Address = 32'd24; WriteData = 32'h0BAD_BEEF;
    @(negedge CLK);
    #1;
    MemWrite = 1'b1; MemRead = 1'b0;
    Address = 32'd20;
    #1;
    vectors++;
    if (DataOut !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL b2b_first: got %h want %h", DataOut, 32'hCAFE_F00D);
    end
    Address = 32'd24;
    #1;
    vectors++;
    if (DataOut !== 32'h0BAD_BEEF) begin
      miscompares++;
      $display("FAIL b2b_second: got %h want %h", DataOut, 32'h0BAD_BEEF);
    end
    Address = 32'd22;
    #1;
    vectors++;
    if (DataOut !== 32'hF00D_0BAD) begin
      miscompares++;
      $display("FAIL b2b_span: got %h want %h", DataOut, 32'hF00D_0BAD);
    end
  endtask

  task automatic test_reset_mid;
    @(posedge CLK);
    #5;
    MemRead = 1'b0; MemWrite = 1'b1;
    Address = 32'd8;
    #1;
    vectors++;
    if (DataOut !== 32'hC3D4_0008) begin
      miscompares++;
      $display("FAIL rm_pre_reset: got %h want %h", DataOut, 32'hC3D4_0008);
    end
    RST = 1'b0;
    #1;
    vectors++;
    if (DataOut !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL rm_read8: got %h want %h", DataOut, 32'h0000_0000);
    end
    Address = 32'd12;
    #1;
    vectors++;
    if (DataOut !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL rm_read12: got %h want %h", DataOut, 32'h0000_0000);
    end
    Address = 32'd8; WriteData = 32'h5555_AAAA; MemWrite = 1'b0;
    @(negedge CLK);
    #1;
    vectors++;
    if (DataOut !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL rm_write_blocked: got %h want %h", DataOut, 32'h0000_0000);
    end
    MemWrite = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(negedge CLK);
    #1;
    vectors++;
    if (DataOut !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL rm_after_release: got %h want %h", DataOut, 32'h0000_0000);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset;
    test_basic;
    test_endian;
    test_write_timing;
    test_overlap;
    test_out_of_range;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Byte-addressed data memory for the single-cycle CPU datapath. Sits after the ALU in the MEM stage.
- Reads are combinational 32-bit big-endian words.
- Writes are 32-bit big-endian words committed on the falling clock edge, leaving the rising edge to the PC and register file.
- Read and write controls are active-low. The read port tri-states when reading is disabled.

Parameters:
- DEPTH, 128, memory size in bytes (must be ≥ 4).
- AW, 32, address width in bits.

Ports:
- CLK  input  1  system clock; writes commit on the falling edge.
- RST  input  1  asynchronous, active-low reset.
- Address  input  32  byte address of the word's most-significant byte.
- WriteData  input  32  word to store.
- MemRead  input  1  active-low read enable (0 = drive DataOut, 1 = high-Z).
- MemWrite  input  1  active-low write enable (0 = write on falling CLK edge, 1 = no operation).
- DataOut  output  32  read data; tri-state.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low. The ports are CLK and RST.
  - RST=0 immediately clears every byte to 8'h00, independent of CLK.
  - Writes are ignored while RST=0.
  - DataOut still obeys MemRead during reset: 32'h0 if MemRead=0, else Z.
- Storage: array of DEPTH 8-bit bytes. Address is used unmodified; no alignment is enforced and no low bits are dropped.
- Read (combinational, zero latency):
  - If MemRead=0 and Address+3 < DEPTH: DataOut = {mem[A], mem[A+1], mem[A+2], mem[A+3]} (big-endian).
  - If MemRead=0 and Address+3 ≥ DEPTH, or Address ≥ DEPTH: DataOut = 32'h00000000.
  - If MemRead=1: DataOut = 32'hZZZZZZZZ.
  - DataOut updates in the same delta whenever Address, MemRead or the memory contents change.
- Write (on the falling CLK edge, when RST=1 and MemWrite=0):
  - mem[A] = WriteData[31:24], mem[A+1] = WriteData[23:16], mem[A+2] = WriteData[15:8], mem[A+3] = WriteData[7:0].
  - Out-of-range words (Address+3 ≥ DEPTH) are silently ignored; no partial write.
  - MemWrite=1: memory unchanged.
- Simultaneous read and write to the same address:
  - DataOut shows the old word until the falling edge, then the new word in the same timestep.
  - There is no read-during-write bypass before the edge.
- Overlapping unaligned words: a write to A affects reads of A-3..A+3 at the byte level.
- Reset asserted mid-cycle with MemWrite=0: no write occurs at the next falling edge while RST=0; memory stays zero.
- Address arithmetic is computed at AW+1 bits so Address near 2^32 cannot wrap into range.
- No X is ever driven on DataOut after reset.

Test Plan:
- Reset then read: RST pulse low, release. MemRead=0, Address=8 → DataOut=0x00000000. MemRead=1 → DataOut=Z.
- Basic write/read:
  - 30 ns clock.
  - Falling edge with Address=8, WriteData=8, MemWrite=0, MemRead=1.
  - Falling edge with Address=12, WriteData=12, MemWrite=0, MemRead=1.
  - MemWrite=1, MemRead=0, Address=8 → 0x00000008.
  - Address=12 → 0x0000000C.
- Endianness/unaligned:
  - Write 0x11223344 at Address 0.
  - Read Address 0 → 0x11223344.
  - Read Address 1 → 0x22334400.
  - Read Address 3 → 0x44000000.
- Write timing: MemWrite=0, Address=16, WriteData=0xDEADBEEF, MemRead=0 held across a rising edge → still 0x00000000. After the next falling edge → 0xDEADBEEF. With MemWrite=1 on that edge → unchanged.
- Out of range:
  - Write 0xFFFFFFFF at Address DEPTH-2 → ignored.
  - Read Address DEPTH-2 → 0x00000000.
  - Read Address DEPTH-4 → 0x00000000, and no byte changed.
- Asynchronous reset mid-operation:
  - After writes at 8 and 12, pulse RST low between clock edges.
  - Reads at 8 and 12 → 0x00000000 immediately.
  - A write requested while RST=0 leaves memory at zero.
